frogger_game_ctrl: RTL

Game-flow sequencer for Frogger. Clocked on Clk; samples the VGA vsync to derive a once-per-frame tick. Consumes the four car-row and four lilypad-row collision flags and the frog Y position. Decides death, goal, respawn, level-up and game-over, and drives the lives/score/level registers. Also drives the frog reset and the freeze control that the frog, car_row and lilypad_row blocks use.

---
 rtl/frogger_game_if.sv | 33 +++
 rtl/frogger_game_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/frogger_game_if.sv
`default_nettype none
// ============================================================================
// Module      : frogger_game_if
// Description : Signal bundle between the Frogger game-flow controller and
//               the play-field blocks (frog, car rows, lilypad rows, display).
// Revision    : 1.0 - initial release
// ============================================================================
interface frogger_game_if;
    logic        Start;
    logic [3:0]  Car_Collision;
    logic [3:0]  LPad_Collision;
    logic [10:0] Frog_Y;
    logic        Frog_Reset;
    logic        Freeze;
    logic        Game_Over;
    logic [2:0]  Lives;
    logic [15:0] Score;
    logic [2:0]  Level;
    logic [2:0]  State;

    // Controller side: consumes play-field status, drives game flow outputs
    modport master (
        input  Start, Car_Collision, LPad_Collision, Frog_Y,
        output Frog_Reset, Freeze, Game_Over, Lives, Score, Level, State
    );

    // Play-field side: the mirror image of the controller
    modport slave (
        output Start, Car_Collision, LPad_Collision, Frog_Y,
        input  Frog_Reset, Freeze, Game_Over, Lives, Score, Level, State
    );
endinterface
`default_nettype wire

// File: rtl/frogger_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : frogger_game_ctrl
// Description : Frogger game-flow sequencer. Derives a per-frame tick from
//               vsync and runs death / goal / respawn / level / game-over
//               flow, owning the lives, BCD score and level registers.
// Revision    : 1.0 - initial release
// ============================================================================
module frogger_game_ctrl #(
    parameter int LIVES_INIT      = 3,
    parameter int DEATH_FRAMES    = 60,
    parameter int GRACE_FRAMES    = 30,
    parameter int GOAL_Y          = 80,
    parameter int RIVER_TOP       = 80,
    parameter int RIVER_BOT       = 239,
    parameter int GOALS_PER_LEVEL = 5,
    parameter int MAX_LEVEL       = 7
) (
    input  wire            Clk,
    input  wire            Reset_n,
    input  wire            frame_clk,
    frogger_game_if.master game
);

    localparam logic [2:0] c_st_idle      = 3'd0;
    localparam logic [2:0] c_st_playing   = 3'd1;
    localparam logic [2:0] c_st_dying     = 3'd2;
    localparam logic [2:0] c_st_goal      = 3'd3;
    localparam logic [2:0] c_st_respawn   = 3'd4;
    localparam logic [2:0] c_st_game_over = 3'd5;

    localparam int c_frame_w = (DEATH_FRAMES > 1) ? $clog2(DEATH_FRAMES) : 1;
    localparam int c_grace_w = (GRACE_FRAMES > 0) ? $clog2(GRACE_FRAMES + 1) : 1;
    localparam int c_goal_w  = (GOALS_PER_LEVEL > 1) ? $clog2(GOALS_PER_LEVEL) : 1;

    localparam logic [c_frame_w-1:0] c_death_last = c_frame_w'(DEATH_FRAMES - 1);
    localparam logic [c_grace_w-1:0] c_grace_init = c_grace_w'(GRACE_FRAMES);
    localparam logic [c_goal_w-1:0]  c_goals_last = c_goal_w'(GOALS_PER_LEVEL - 1);
    localparam logic [2:0]           c_lives_init = 3'(LIVES_INIT);
    localparam logic [2:0]           c_max_level  = 3'(MAX_LEVEL);
    localparam logic [10:0]          c_goal_y     = 11'(GOAL_Y);
    localparam logic [10:0]          c_river_top  = 11'(RIVER_TOP);
    localparam logic [10:0]          c_river_bot  = 11'(RIVER_BOT);

    logic                 r_fclk_meta, r_fclk_sync, r_fclk_prev;
    logic [2:0]           r_state, w_state_next;
    logic [2:0]           r_lives, r_level;
    logic [15:0]          r_score, w_score_next;
    logic [c_goal_w-1:0]  r_goal_cnt;
    logic [c_frame_w-1:0] r_frame_cnt;
    logic [c_grace_w-1:0] r_grace_cnt;
    logic                 r_start_prev;
    logic                 w_frog_reset, w_freeze, w_game_over;

    // Two-stage synchronizer plus edge history for the asynchronous vsync
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_fclk_meta <= 1'b0;
            r_fclk_sync <= 1'b0;
            r_fclk_prev <= 1'b0;
        end else begin
            r_fclk_meta <= frame_clk;
            r_fclk_sync <= r_fclk_meta;
            r_fclk_prev <= r_fclk_sync;
        end
    end

    wire w_tick    = r_fclk_sync & ~r_fclk_prev;
    wire w_car_hit = |game.Car_Collision;
    wire w_drown   = (game.Frog_Y >= c_river_top) && (game.Frog_Y <= c_river_bot)
                     && ~|game.LPad_Collision;
    wire w_goal    = game.Frog_Y < c_goal_y;
    // Grace masks deaths only; the registered count is used, so the window
    // covers the first GRACE_FRAMES playing ticks after respawn.
    wire w_death   = (w_car_hit | w_drown) && (r_grace_cnt == '0);
    wire w_restart = game.Start && !r_start_prev;
    wire w_init    = ((r_state == c_st_idle) && game.Start)
                     || ((r_state == c_st_game_over) && w_restart);

    // FSM state register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) r_state <= c_st_idle;
        else          r_state <= w_state_next;
    end

    // FSM next-state logic; every transition waits for a frame tick
    always_comb begin
        w_state_next = r_state;
        if (w_tick) begin
            case (r_state)
                c_st_idle:      if (game.Start) w_state_next = c_st_respawn;
                c_st_respawn:   w_state_next = c_st_playing;
                c_st_playing: begin
                    if (w_death)     w_state_next = c_st_dying;
                    else if (w_goal) w_state_next = c_st_goal;
                end
                c_st_dying: begin
                    if (r_frame_cnt == '0)
                        w_state_next = (r_lives <= 3'd1) ? c_st_game_over : c_st_respawn;
                end
                c_st_goal:      w_state_next = c_st_respawn;
                c_st_game_over: if (w_restart) w_state_next = c_st_respawn;
                default:        w_state_next = c_st_idle;
            endcase
        end
    end

    // FSM outputs: frog hold / motion freeze / game-over flag per state
    always_comb begin
        w_frog_reset = 1'b1;
        w_freeze     = 1'b1;
        w_game_over  = 1'b0;
        case (r_state)
            c_st_respawn:   w_freeze     = 1'b0;
            c_st_playing: begin
                w_frog_reset = 1'b0;
                w_freeze     = 1'b0;
            end
            c_st_dying:     w_frog_reset = 1'b0;
            c_st_goal:      w_frog_reset = 1'b0;
            c_st_game_over: w_game_over  = 1'b1;
            default: ;
        endcase
    end

    // Score plus ten in BCD: ones digit is always zero, saturate at 9999
    always_comb begin
        w_score_next = r_score;
        if (r_score[15:4] == 12'h999) begin
            w_score_next = 16'h9999;
        end else if (r_score[7:4] != 4'h9) begin
            w_score_next[7:4] = r_score[7:4] + 4'h1;
        end else if (r_score[11:8] != 4'h9) begin
            w_score_next[7:4]  = 4'h0;
            w_score_next[11:8] = r_score[11:8] + 4'h1;
        end else begin
            w_score_next[7:4]   = 4'h0;
            w_score_next[11:8]  = 4'h0;
            w_score_next[15:12] = r_score[15:12] + 4'h1;
        end
    end

    // Game bookkeeping: lives, score, level and frame counters, tick-gated
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_lives      <= c_lives_init;
            r_score      <= 16'h0000;
            r_level      <= 3'd0;
            r_goal_cnt   <= '0;
            r_frame_cnt  <= '0;
            r_grace_cnt  <= '0;
            r_start_prev <= 1'b0;
        end else if (w_tick) begin
            r_start_prev <= game.Start;
            if (w_init) begin
                r_lives    <= c_lives_init;
                r_score    <= 16'h0000;
                r_level    <= 3'd0;
                r_goal_cnt <= '0;
            end
            case (r_state)
                c_st_respawn: r_grace_cnt <= c_grace_init;
                c_st_playing: begin
                    if (r_grace_cnt != '0) r_grace_cnt <= r_grace_cnt - 1'b1;
                    if (w_death)           r_frame_cnt <= c_death_last;
                end
                c_st_dying: begin
                    if (r_frame_cnt != '0)  r_frame_cnt <= r_frame_cnt - 1'b1;
                    else if (r_lives != '0) r_lives     <= r_lives - 3'd1;
                end
                c_st_goal: begin
                    r_score <= w_score_next;
                    if (r_goal_cnt == c_goals_last) begin
                        r_goal_cnt <= '0;
                        if (r_level != c_max_level) r_level <= r_level + 3'd1;
                    end else begin
                        r_goal_cnt <= r_goal_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign game.Frog_Reset = w_frog_reset;
    assign game.Freeze     = w_freeze;
    assign game.Game_Over  = w_game_over;
    assign game.Lives      = r_lives;
    assign game.Score      = r_score;
    assign game.Level      = r_level;
    assign game.State      = r_state;

endmodule
`default_nettype wire
